// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and receiver: FSM states,
// frame constants and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int   DATA_BITS   = 8;
    localparam logic LINE_IDLE   = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // Even parity makes the total count of ones even; odd parity inverts that bit.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, pulses wrap on the last count,
// and is held at zero while clr is high. Shared by the UART transmitter and receiver.
module uart_baud_cnt #(
    parameter int unsigned CLKS_PER_BIT = 100
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clr,
    output logic [$clog2(CLKS_PER_BIT)-1:0] cnt,
    output logic                            wrap
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        wrap  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
        cnt_d = (clr || wrap) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts a byte per valid/ready handshake and sends it as
// start bit, 8 data bits LSB first, optional parity and 1 or 2 stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 100,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_dv,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_serial,
    output logic                 tx_active,
    output logic                 tx_done
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);

    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
        $error("uart_tx: CLKS_PER_BIT must be in 2..65535");
    end

    // The done/IDLE cycle doubles as the final stop-bit cycle, so STOP is left one
    // count early; this keeps back-to-back frames at exact line rate.
    localparam logic [CNT_W-1:0] LAST_STOP_CNT = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0] LAST_STOP_IDX = BIT_W'(STOP_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_DATA_IDX = BIT_W'(DATA_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 parity_q, parity_d;
    logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 tx_serial_q, tx_serial_d;
    logic                 tx_active_q, tx_active_d;
    logic                 tx_done_q, tx_done_d;

    logic [CNT_W-1:0]     clk_cnt;
    logic                 bit_wrap;

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_q == IDLE),
        .cnt  (clk_cnt),
        .wrap (bit_wrap)
    );

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        parity_d    = parity_q;
        bit_idx_d   = bit_idx_q;
        tx_serial_d = tx_serial_q;
        tx_active_d = tx_active_q;
        tx_done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                tx_serial_d = LINE_IDLE;
                tx_active_d = 1'b0;
                if (tx_dv) begin
                    shreg_d     = tx_data;
                    parity_d    = parity_bit(tx_data, PARITY_ODD != 0);
                    bit_idx_d   = '0;
                    tx_serial_d = START_LEVEL;
                    tx_active_d = 1'b1;
                    state_d     = START;
                end
            end
            START: begin
                if (bit_wrap) begin
                    bit_idx_d   = '0;
                    tx_serial_d = shreg_q[0];
                    state_d     = DATA;
                end
            end
            DATA: begin
                if (bit_wrap) begin
                    if (bit_idx_q != LAST_DATA_IDX) begin
                        bit_idx_d   = bit_idx_q + 1'b1;
                        tx_serial_d = shreg_q[bit_idx_q + 1'b1];
                    end else if (PARITY_EN != 0) begin
                        tx_serial_d = parity_q;
                        state_d     = PARITY;
                    end else begin
                        bit_idx_d   = '0;
                        tx_serial_d = LINE_IDLE;
                        state_d     = STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_wrap) begin
                    bit_idx_d   = '0;
                    tx_serial_d = LINE_IDLE;
                    state_d     = STOP;
                end
            end
            STOP: begin
                tx_serial_d = LINE_IDLE;
                if (bit_idx_q == LAST_STOP_IDX && clk_cnt == LAST_STOP_CNT) begin
                    bit_idx_d   = '0;
                    tx_active_d = 1'b0;
                    tx_done_d   = 1'b1;
                    state_d     = IDLE;
                end else if (bit_wrap) begin
                    bit_idx_d = bit_idx_q + 1'b1;
                end
            end
            default: begin
                tx_serial_d = LINE_IDLE;
                tx_active_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            parity_q    <= 1'b0;
            bit_idx_q   <= '0;
            tx_serial_q <= LINE_IDLE;
            tx_active_q <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            parity_q    <= parity_d;
            bit_idx_q   <= bit_idx_d;
            tx_serial_q <= tx_serial_d;
            tx_active_q <= tx_active_d;
            tx_done_q   <= tx_done_d;
        end
    end

    assign tx_ready  = (state_q == IDLE);
    assign tx_serial = tx_serial_q;
    assign tx_active = tx_active_q;
    assign tx_done   = tx_done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: five configurations share one clock and reset; a frame-level
// model predicts every output each cycle, and directed frames pin the model with literals.
module tb_uart_tx;

    localparam int NDUT = 5;
    localparam int CPB_A [NDUT] = '{100, 100, 100, 100, 2};
    localparam int PEN_A [NDUT] = '{0,   1,   1,   0,   1};
    localparam int POD_A [NDUT] = '{0,   0,   1,   0,   1};
    localparam int SB_A  [NDUT] = '{1,   1,   1,   2,   2};

    typedef struct packed {
        logic ser;
        logic act;
        logic done;
        logic rdy;
    } exp_t;

    localparam exp_t IDLE_EXP = '{ser: 1'b1, act: 1'b0, done: 1'b0, rdy: 1'b1};

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NDUT-1:0] dv  = '0;
    logic [7:0]      data [NDUT];
    wire  [NDUT-1:0] ready;
    wire  [NDUT-1:0] ser;
    wire  [NDUT-1:0] act;
    wire  [NDUT-1:0] done;

    int   n_checks = 0;
    int   n_pass   = 0;
    bit   model_on = 1'b0;
    exp_t exp_q [NDUT][$];
    exp_t cur   [NDUT];

    logic line_s [0:2300];
    logic done_s [0:2300];
    logic rdy_s  [0:2300];
    logic act_s  [0:2300];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        uart_tx #(
            .CLKS_PER_BIT (CPB_A[g]),
            .PARITY_EN    (PEN_A[g]),
            .PARITY_ODD   (POD_A[g]),
            .STOP_BITS    (SB_A[g])
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .tx_dv     (dv[g]),
            .tx_data   (data[g]),
            .tx_ready  (ready[g]),
            .tx_serial (ser[g]),
            .tx_active (act[g]),
            .tx_done   (done[g])
        );
    end

    // Expand an accepted byte into the per-cycle outputs of its whole frame.
    task automatic push_frame(input int i, input logic [7:0] b);
        int   cpb;
        int   f;
        int   ones;
        int   pos;
        logic par;
        logic lvl;
        cpb  = CPB_A[i];
        f    = (9 + PEN_A[i] + SB_A[i]) * cpb;
        ones = 0;
        for (int k = 0; k < 8; k++) ones += int'(b[k]);
        par = (ones % 2 == 1) ^ (POD_A[i] != 0);
        for (int j = 0; j < f; j++) begin
            pos = j / cpb;
            if (pos == 0)                      lvl = 1'b0;
            else if (pos <= 8)                 lvl = b[pos-1];
            else if (pos == 9 && PEN_A[i] != 0) lvl = par;
            else                               lvl = 1'b1;
            exp_q[i].push_back('{ser: lvl, act: (j < f - 1), done: (j == f - 1), rdy: (j == f - 1)});
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            if (rst) begin
                exp_q[i].delete();
                cur[i] = IDLE_EXP;
            end else begin
                if (dv[i] && cur[i].rdy) push_frame(i, data[i]);
                cur[i] = (exp_q[i].size() > 0) ? exp_q[i].pop_front() : IDLE_EXP;
            end
        end
        if (rst) model_on = 1'b1;
    end

    always @(negedge clk) begin
        if (model_on) begin
            for (int i = 0; i < NDUT; i++) begin
                n_checks++;
                if ({ser[i], act[i], done[i], ready[i]} === cur[i]) n_pass++;
                else $display("[TB] FAIL model dut%0d: got ser/act/done/rdy=%b, want %b",
                              i, {ser[i], act[i], done[i], ready[i]}, cur[i]);
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("[TB] FAIL %s: got %0h, want %0h", name, got, want);
    endtask

    // Accept b on dut i, then record ncyc cycles; cycle n is the one after edge k+n-1.
    task automatic apply_stimulus(input int i, input logic [7:0] b, input int ncyc,
                                  input int hold, input logic [7:0] b2, input bit scramble);
        @(negedge clk);
        data[i] = b;
        dv[i]   = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            if (n > hold) dv[i] = 1'b0;
            if (scramble)    data[i] = 8'($urandom);
            else if (n == 1) data[i] = b2;
            line_s[n] = ser[i];
            done_s[n] = done[i];
            rdy_s[n]  = ready[i];
            act_s[n]  = act[i];
        end
    endtask

    function automatic logic [7:0] decode(input int off);
        logic [7:0] v;
        for (int b = 0; b < 8; b++) v[b] = line_s[off + 100 * (b + 1) + 50];
        return v;
    endfunction

    function automatic int first_done(input int from, input int to);
        for (int n = from; n <= to; n++) if (done_s[n] === 1'b1) return n;
        return -1;
    endfunction

    initial begin
        int cnt;
        for (int i = 0; i < NDUT; i++) data[i] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset_serial", ser[0], 1);
        check_output("reset_active", act[0], 0);
        check_output("reset_done", done[0], 0);
        check_output("reset_ready", ready[0], 1);
        rst = 1'b0;

        apply_stimulus(0, 8'hCD, 1005, 0, 8'h00, 1'b0);
        check_output("cd_start_bit", line_s[50], 0);
        check_output("cd_start_first", line_s[1], 0);
        check_output("cd_bit0", line_s[150], 1);
        check_output("cd_bit1", line_s[250], 0);
        check_output("cd_byte", decode(0), 8'hCD);
        check_output("cd_stop", line_s[999], 1);
        check_output("cd_done_cycle", first_done(1, 1005), 1000);
        check_output("cd_active_last", act_s[999], 1);
        check_output("cd_active_fall", act_s[1000], 0);
        cnt = 0;
        for (int n = 1; n < 1000; n++) cnt += int'(rdy_s[n] === 1'b1);
        check_output("cd_ready_busy", cnt, 0);

        apply_stimulus(1, 8'hCD, 1105, 0, 8'h00, 1'b0);
        check_output("even_parity_bit", line_s[950], 1);
        check_output("even_byte", decode(0), 8'hCD);
        check_output("even_done_cycle", first_done(1, 1105), 1100);

        apply_stimulus(2, 8'hCD, 1105, 0, 8'h00, 1'b0);
        check_output("odd_parity_bit", line_s[950], 0);
        check_output("odd_done_cycle", first_done(1, 1105), 1100);

        apply_stimulus(3, 8'h00, 2205, 1100, 8'hFF, 1'b0);
        check_output("b2b_last_data", line_s[900], 0);
        check_output("b2b_stop_begin", line_s[901], 1);
        check_output("b2b_stop_end", line_s[1100], 1);
        check_output("b2b_second_start", line_s[1101], 0);
        cnt = 0;
        for (int n = 901; n <= 1100; n++) cnt += int'(line_s[n] === 1'b1);
        check_output("b2b_stop_len", cnt, 200);
        check_output("b2b_first_byte", decode(0), 8'h00);
        check_output("b2b_second_byte", decode(1100), 8'hFF);
        check_output("b2b_done1", first_done(1, 2205), 1100);
        check_output("b2b_done2", first_done(1101, 2205), 2200);

        apply_stimulus(0, 8'h5A, 349, 0, 8'h00, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_output("midrst_serial", ser[0], 1);
        check_output("midrst_active", act[0], 0);
        check_output("midrst_done", done[0], 0);
        check_output("midrst_ready", ready[0], 1);
        rst = 1'b0;
        cnt = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            cnt += int'(done[0] === 1'b1);
        end
        check_output("midrst_no_done", cnt, 0);
        apply_stimulus(0, 8'hA5, 1005, 0, 8'h00, 1'b0);
        check_output("after_rst_byte", decode(0), 8'hA5);
        check_output("after_rst_done", first_done(1, 1005), 1000);

        apply_stimulus(0, 8'h3C, 1005, 0, 8'h00, 1'b1);
        check_output("scramble_byte", decode(0), 8'h3C);

        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            dv[4]   = 1'($urandom);
            data[4] = 8'($urandom);
        end
        dv[4] = 1'b0;
        repeat (30) @(negedge clk);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
